// File: rtl/dbus_sram_responder.sv
// DBus responder backed by a word-organised SRAM model.
// In-order responses at a fixed latency, with a bounded number of requests in flight.
module dbus_sram_responder #(
  parameter  int ADDR_W   = 12,
  parameter  int RESP_LAT = 2,
  parameter  int MAX_OUT  = 2,
  localparam int CNT_W    = $clog2(MAX_OUT + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             dcache_req,
  input  logic             dcache_wr,
  input  logic [3:0]       dcache_wstrb,
  input  logic [2:0]       dcache_size,
  input  logic [31:0]      dcache_addr,
  input  logic [31:0]      dcache_wdata,
  output logic             dcache_addr_ok,
  output logic             dcache_data_ok,
  output logic [31:0]      dcache_rdata,
  output logic [CNT_W-1:0] outstanding,
  output logic             misalign_err
);

  logic [31:0]       mem [2**ADDR_W];
  logic [ADDR_W-1:0] idx;
  logic              take;
  logic              misaligned;

  logic [RESP_LAT-1:0] pipe_v;
  logic [RESP_LAT-1:0] pipe_w;
  logic [31:0]         pipe_d [RESP_LAT];

  // Upper address bits are deliberately ignored so accesses wrap.
  logic unused_addr;
  assign unused_addr = ^dcache_addr[31:ADDR_W+2];

  assign idx  = dcache_addr[ADDR_W+1:2];
  // A response retiring this cycle frees its slot for a same-cycle accept.
  assign dcache_addr_ok = dcache_req && !stall && !reset &&
                          ((outstanding < CNT_W'(MAX_OUT)) || dcache_data_ok);
  assign take = dcache_addr_ok;

  // Sizes above word are checked as words.
  assign misaligned = ((dcache_size == 3'd1) && dcache_addr[0]) ||
                      ((dcache_size >= 3'd2) && (dcache_addr[1:0] != 2'b00));

  assign dcache_data_ok = pipe_v[RESP_LAT-1];
  assign dcache_rdata   = (pipe_v[RESP_LAT-1] && !pipe_w[RESP_LAT-1]) ?
                          pipe_d[RESP_LAT-1] : 32'h0;

  always_ff @(posedge clk) begin
    if (take && dcache_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (dcache_wstrb[i]) mem[idx][8*i +: 8] <= dcache_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_v <= '0;
      pipe_w <= '0;
      for (int i = 0; i < RESP_LAT; i++) pipe_d[i] <= 32'h0;
    end else begin
      pipe_v[0] <= take;
      pipe_w[0] <= dcache_wr;
      pipe_d[0] <= mem[idx];
      for (int i = 1; i < RESP_LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_w[i] <= pipe_w[i-1];
        pipe_d[i] <= pipe_d[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outstanding  <= '0;
      misalign_err <= 1'b0;
    end else begin
      case ({take, dcache_data_ok})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
      if (take && misaligned) misalign_err <= 1'b1;
    end
  end

endmodule
